// File: rtl/kypd_scanner.sv
// 4x4 hex keypad scanner with whole-scan debounce and press pulses.
// Define KYPD_ACCUM_EN to shift accepted digits into value.
module kypd_scanner #(
   parameter int SCAN_CYCLES    = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  row,
   output logic [3:0]  col,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic        key_held,
   input  logic        clr,
   output logic [31:0] value
);

   localparam int CW = $clog2(SCAN_CYCLES);
   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_CYCLES - 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SCANS);
   // hex code per image bit, bit index = 4*row + col
   localparam logic [63:0] KEY_MAP = 64'hDEF0_C987_B654_A321;

   typedef enum logic {RELEASED, PRESSED} state_t;

   state_t          state;
   logic [3:0]      row_s1, row_s2;
   logic [CW-1:0]   cyc;
   logic [1:0]      col_idx, idx_nxt;
   logic [15:0]     img, img_nxt, prev;
   logic [SW-1:0]   stab, stab_nxt;
   logic [4:0]      cnt;
   logic [3:0]      hit;
   logic [3:0]      new_code;
   logic            last, done, accept, release_ok;

   assign last    = (cyc == CYC_LAST);
   assign done    = last && (col_idx == 2'd3);
   assign idx_nxt = last ? col_idx + 2'd1 : col_idx;

   always_comb begin
      img_nxt = img;
      if (last) begin
         img_nxt[{2'd0, col_idx}] = ~row_s2[0];
         img_nxt[{2'd1, col_idx}] = ~row_s2[1];
         img_nxt[{2'd2, col_idx}] = ~row_s2[2];
         img_nxt[{2'd3, col_idx}] = ~row_s2[3];
      end
   end

   always_comb begin
      cnt = '0;
      hit = '0;
      for (int i = 0; i < 16; i++) begin
         cnt = cnt + 5'(img_nxt[i]);
         if (img_nxt[i]) hit = 4'(i);
      end
   end

   assign new_code = KEY_MAP[{hit, 2'b00} +: 4];

   always_comb begin
      stab_nxt = SW'(1);
      if (img_nxt == prev)
         stab_nxt = (stab == STAB_MAX) ? stab : stab + 1'b1;
   end

   assign accept = done && (state == RELEASED) &&
                   (stab_nxt == STAB_MAX) && (cnt == 5'd1);
   assign release_ok = done && (state == PRESSED) &&
                       (stab_nxt == STAB_MAX) && (cnt == 5'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         row_s1    <= 4'hF;
         row_s2    <= 4'hF;
         cyc       <= '0;
         col_idx   <= '0;
         col       <= 4'b1111;
         img       <= '0;
         prev      <= '0;
         stab      <= '0;
         state     <= RELEASED;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
      end else begin
         row_s1    <= row;
         row_s2    <= row_s1;
         cyc       <= last ? '0 : cyc + 1'b1;
         col_idx   <= idx_nxt;
         col       <= ~(4'b0001 << idx_nxt);
         img       <= img_nxt;
         key_valid <= 1'b0;
         if (done) begin
            prev <= img_nxt;
            stab <= stab_nxt;
         end
         if (accept) begin
            state     <= PRESSED;
            key_code  <= new_code;
            key_valid <= 1'b1;
            key_held  <= 1'b1;
         end else if (release_ok) begin
            state    <= RELEASED;
            key_held <= 1'b0;
         end
      end
   end

`ifdef KYPD_ACCUM_EN
   // value moves on the same edge as key_valid
   always_ff @(posedge clk) begin
      if (rst)
         value <= '0;
      else if (accept)
         value <= clr ? {28'b0, new_code} : {value[27:0], new_code};
      else if (clr)
         value <= '0;
   end
`else
   logic unused_clr;
   assign unused_clr = clr;
   assign value = '0;
`endif

endmodule

// File: tb/tb_kypd_scanner.sv
// Scoreboard bench for kypd_scanner: keypad model drives rows from col,
// expected presses are queued and checked by a key_valid monitor.
module tb_kypd_scanner;

   localparam int SC   = 8;
   localparam int DEB  = 3;
   localparam int SCAN = 4 * SC;
`ifdef KYPD_ACCUM_EN
   localparam bit ACC = 1'b1;
`else
   localparam bit ACC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [31:0] value;
   logic [15:0] keys = '0;

   int checks = 0;
   int errors = 0;
   logic [35:0] exp_q[$];
   logic [31:0] exp_val = '0;
   logic        prev_kv = 1'b0;

   kypd_scanner #(.SCAN_CYCLES(SC), .DEBOUNCE_SCANS(DEB)) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
      .clr(clr), .value(value)
   );

   always #5 clk = ~clk;

   // a row reads low when a pressed key sits on a driven-low column
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
   end

   function automatic int kidx(input logic [3:0] k);
      case (k)
         4'h1: return 0;  4'h2: return 1;  4'h3: return 2;  4'hA: return 3;
         4'h4: return 4;  4'h5: return 5;  4'h6: return 6;  4'hB: return 7;
         4'h7: return 8;  4'h8: return 9;  4'h9: return 10; 4'hC: return 11;
         4'h0: return 12; 4'hF: return 13; 4'hE: return 14; default: return 15;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_key(input logic [3:0] k);
      if (ACC) exp_val = {exp_val[27:0], k};
      exp_q.push_back({k, exp_val});
   endtask

   task automatic key_mask(input logic [3:0] k, output logic [15:0] m);
      m = '0;
      m[kidx(k)] = 1'b1;
   endtask

   task automatic scan_start();
      int n = 0;
      while (col !== 4'b0111 && n < 200) begin @(negedge clk); n++; end
      while (col !== 4'b1110 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL scan_start: got timeout expected col 1110");
      end
   endtask

   task automatic press_release(input logic [3:0] k);
      logic [15:0] m;
      key_mask(k, m);
      keys = m;
      expect_key(k);
      cycles(6 * SCAN);
      chk("pending", 32'(exp_q.size()), 0);
      chk("held_on", {31'b0, key_held}, 1);
      chk("code", {28'b0, key_code}, {28'b0, k});
      keys = '0;
      cycles(5 * SCAN);
      chk("held_off", {31'b0, key_held}, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && key_valid) begin
         chk("kv_gap", {31'b0, prev_kv}, 0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got code %h expected none",
                     key_code);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            chk("pulse_code", {28'b0, key_code}, {28'b0, e[35:32]});
            chk("pulse_value", value, e[31:0]);
            chk("pulse_held", {31'b0, key_held}, 1);
         end
      end
      prev_kv = key_valid;
   end

   initial begin
      logic [15:0] m;
      cycles(3);
      chk("rst_col", {28'b0, col}, 32'hF);
      chk("rst_code", {28'b0, key_code}, 0);
      chk("rst_valid", {31'b0, key_valid}, 0);
      chk("rst_held", {31'b0, key_held}, 0);
      chk("rst_value", value, 0);
      rst = 1'b0;

      scan_start();
      chk("col0", {28'b0, col}, 32'hE);
      cycles(SC);
      chk("col1", {28'b0, col}, 32'hD);
      cycles(SC);
      chk("col2", {28'b0, col}, 32'hB);
      cycles(SC);
      chk("col3", {28'b0, col}, 32'h7);
      cycles(3 * SCAN);
      chk("idle_value", value, 0);

      press_release(4'h5);
      chk("value5", value, ACC ? 32'h5 : 32'h0);

      for (int d = 1; d <= 9; d++) press_release(4'(d));
      chk("value9", value, ACC ? 32'h23456789 : 32'h0);

      // bouncing D: sampled D image is never stable for 3 scans
      key_mask(4'hD, m);
      scan_start();
      for (int c = 0; c < 4 * SCAN; c++) begin
         keys = ((c / 5) % 2 == 0) ? m : '0;
         cycles(1);
      end
      keys = m;
      expect_key(4'hD);
      cycles(5 * SCAN);
      chk("bounce_pending", 32'(exp_q.size()), 0);
      chk("bounce_code", {28'b0, key_code}, 32'hD);
      keys = '0;
      cycles(5 * SCAN);

      keys = 16'b0000_0000_0000_0011;
      cycles(6 * SCAN);
      chk("multi_held", {31'b0, key_held}, 0);
      keys = 16'b0000_0000_0000_0001;
      expect_key(4'h1);
      cycles(6 * SCAN);
      chk("multi_pending", 32'(exp_q.size()), 0);
      chk("multi_code", {28'b0, key_code}, 32'h1);
      keys = '0;
      cycles(5 * SCAN);

      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      exp_val = '0;
      chk("clr_value", value, 0);
      for (int d = 1; d <= 4; d++) press_release(4'(d));
      chk("value1234", value, ACC ? 32'h1234 : 32'h0);

      // A accepted at the end of its third scan; clr on that edge
      key_mask(4'hA, m);
      scan_start();
      keys = m;
      exp_val = ACC ? 32'hA : 32'h0;
      exp_q.push_back({4'hA, exp_val});
      cycles(3 * SCAN - 1);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      cycles(2 * SCAN);
      chk("clrA_pending", 32'(exp_q.size()), 0);
      chk("clrA_value", value, ACC ? 32'hA : 32'h0);
      keys = '0;
      cycles(5 * SCAN);

      key_mask(4'h7, m);
      keys = m;
      expect_key(4'h7);
      cycles(6 * SCAN);
      chk("r7_pending", 32'(exp_q.size()), 0);
      rst = 1'b1;
      cycles(2);
      chk("mid_rst_col", {28'b0, col}, 32'hF);
      chk("mid_rst_code", {28'b0, key_code}, 0);
      chk("mid_rst_held", {31'b0, key_held}, 0);
      chk("mid_rst_value", value, 0);
      rst = 1'b0;
      exp_val = '0;
      expect_key(4'h7);
      cycles(6 * SCAN);
      chk("r7b_pending", 32'(exp_q.size()), 0);
      chk("r7b_held", {31'b0, key_held}, 1);
      chk("r7b_value", value, ACC ? 32'h7 : 32'h0);
      keys = '0;
      cycles(5 * SCAN);
      chk("final_held", {31'b0, key_held}, 0);
      chk("final_pending", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
